// File: rtl/lc3_fetch_pkg.sv
// lc3_fetch_pkg
//   Shared types and constants for the LC3 instruction-fetch sequencer.
//   fetch_state_e : sequencer states (IDLE, REQ, DRAIN)
//   fetch_entry_t : one prefetched word plus the address it came from
//   LC3_RESET_PC  : default first fetch address after reset
package lc3_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetch_entry_t;

  localparam logic [15:0] LC3_RESET_PC = 16'h3000;

endpackage

// File: rtl/lc3_fetch_fifo.sv
// lc3_fetch_fifo
//   Synchronous prefetch FIFO of fetch_entry_t.  Flush empties the FIFO and
//   overrides any push or pop in the same cycle.  A push into a full FIFO is
//   only accepted when a pop happens in the same cycle.
// Ports
//   clock, reset        clock, synchronous active-high reset
//   push, push_data     write request and entry
//   pop                 remove head entry (ignored when empty)
//   flush               discard all entries
//   head                oldest entry (only meaningful when !empty)
//   count, full, empty  occupancy
import lc3_fetch_pkg::*;

module lc3_fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/lc3_fetch_ctrl.sv
// lc3_fetch_ctrl
//   Instruction-fetch sequencer between the LC3 core and instruction memory.
//   Issues one request at a time, buffers returned words in a prefetch FIFO
//   and handles branch redirects (flush + drain of an in-flight fetch).
//   Optional feature macro: FETCH_TIMEOUT_EN (sticky fetch_err on a stalled
//   request; without it fetch_err is tied low).
// Ports
//   clock, reset                 clock, synchronous active-high reset
//   PC, instrmem_rd              registered fetch address / request
//   instr_dout, complete_instr   memory response data / strobe
//   br_taken, br_target          redirect strobe / address
//   decode_ready                 decode consumes the head entry
//   instr_valid, instr           FIFO head valid / word
//   instr_pc, npc                head address / head address + 1
//   fetch_err                    sticky timeout flag
//
// state | meaning
// IDLE  | no request outstanding (FIFO full or just reset)
// REQ   | request at PC outstanding; response is pushed to the FIFO
// DRAIN | redirect arrived mid-fetch; wait for and drop the stale response
import lc3_fetch_pkg::*;

module lc3_fetch_ctrl #(
  parameter logic [15:0] RESET_PC   = LC3_RESET_PC,
  parameter int          FIFO_DEPTH = 2
`ifdef FETCH_TIMEOUT_EN
  // Only present when the timeout feature is built in.
  , parameter int        TIMEOUT_CYCLES = 64
`endif
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] PC,
  output logic        instrmem_rd,
  input  logic [15:0] instr_dout,
  input  logic        complete_instr,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        decode_ready,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [15:0] npc,
  output logic        fetch_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e   state_q, state_d;
  logic [15:0]    pc_q, pc_d;
  logic [15:0]    tgt_q, tgt_d;
  logic           rd_q, rd_d;

  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count, occ_push;
  fetch_entry_t   fifo_head, push_entry;

  assign push_entry = '{pc: pc_q, instr: instr_dout};
  assign fifo_pop   = !fifo_empty && decode_ready;
  // Occupancy after a push this cycle, counting a same-cycle pop.
  assign occ_push   = fifo_count + CW'(1) - CW'(fifo_pop);

  lc3_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (br_taken),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    rd_d      = rd_q;
    fifo_push = 1'b0;
    case (state_q)
      IDLE: begin
        // Late responses from an abandoned request are ignored here.
        if (br_taken) begin
          pc_d    = br_target;
          state_d = REQ;
          rd_d    = 1'b1;
        end else if (!fifo_full || fifo_pop) begin
          state_d = REQ;
          rd_d    = 1'b1;
        end
      end
      REQ: begin
        if (br_taken) begin
          if (complete_instr) begin
            pc_d = br_target;
          end else begin
            tgt_d   = br_target;
            state_d = DRAIN;
          end
        end else if (complete_instr) begin
          fifo_push = 1'b1;
          pc_d      = pc_q + 16'd1;
          if (occ_push >= CW'(FIFO_DEPTH)) begin
            state_d = IDLE;
            rd_d    = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (complete_instr) begin
          pc_d    = br_taken ? br_target : tgt_q;
          state_d = REQ;
        end else if (br_taken) begin
          tgt_d = br_target;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      rd_q    <= rd_d;
    end
  end

  assign PC          = pc_q;
  assign instrmem_rd = rd_q;
  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? 16'h0000 : fifo_head.instr;
  assign instr_pc    = fifo_empty ? 16'h0000 : fifo_head.pc;
  assign npc         = fifo_empty ? 16'h0000 : fifo_head.pc + 16'd1;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          waiting;

  // Down-counter reloaded whenever no request is stalled; the terminal
  // count sets the sticky flag while the fetch keeps waiting.
  always_comb begin
    waiting = (state_q != IDLE) && !complete_instr;
    tmo_d   = TW'(TIMEOUT_CYCLES);
    err_d   = err_q;
    if (waiting) begin
      tmo_d = (tmo_q != '0) ? tmo_q - TW'(1) : '0;
      if (tmo_q == TW'(1)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_q <= TW'(TIMEOUT_CYCLES);
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_fetch_ctrl.sv
module tb_lc3_fetch_ctrl;

  localparam int          DEPTH  = 2;
  localparam logic [15:0] RST_PC = 16'h3000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] PC;
  logic        instrmem_rd;
  logic [15:0] instr_dout = '0;
  logic        complete_instr = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = '0;
  logic        decode_ready = 1'b0;
  logic        instr_valid;
  logic [15:0] instr, instr_pc, npc;
  logic        fetch_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  lc3_fetch_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .PC             (PC),
    .instrmem_rd    (instrmem_rd),
    .instr_dout     (instr_dout),
    .complete_instr (complete_instr),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .decode_ready   (decode_ready),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .npc            (npc),
    .fetch_err      (fetch_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ci, input logic [15:0] dout, input logic bt,
                       input logic [15:0] tgt, input logic dr);
    complete_instr = ci;
    instr_dout     = dout;
    br_taken       = bt;
    br_target      = tgt;
    decode_ready   = dr;
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reset state, first fetch, 1-cycle push latency.
  task automatic test_reset();
    do_reset();
    vectors++;
    if (instrmem_rd !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 || PC !== RST_PC ||
        instr !== 16'h0 || instr_pc !== 16'h0 || npc !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: rd=%b valid=%b err=%b PC=%h instr=%h ipc=%h npc=%h, required rd=0 valid=0 err=0 PC=3000 instr/ipc/npc=0",
               instrmem_rd, instr_valid, fetch_err, PC, instr, instr_pc, npc);
    end
    tick();
    vectors++;
    if (instrmem_rd !== 1'b1 || PC !== 16'h3000) begin
      miscompares++;
      $display("FAIL first_req: rd=%b PC=%h, required rd=1 PC=3000", instrmem_rd, PC);
    end
    tick();
    drive(1'b1, 16'hA001, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (instrmem_rd !== 1'b1 || PC !== 16'h3000 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL req_held: rd=%b PC=%h valid=%b, required rd=1 PC=3000 valid=0", instrmem_rd, PC, instr_valid);
    end
    tick();
    vectors++;
    if (instr_valid !== 1'b1 || instr !== 16'hA001 || instr_pc !== 16'h3000 || npc !== 16'h3001 ||
        PC !== 16'h3001 || instrmem_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL first_push: valid=%b instr=%h ipc=%h npc=%h PC=%h rd=%b, required 1 A001 3000 3001 3001 1",
               instr_valid, instr, instr_pc, npc, PC, instrmem_rd);
    end
  endtask

  // Continues from test_reset: second push fills the FIFO, one pop restarts fetching.
  task automatic test_fifo_full();
    drive(1'b1, 16'hB002, 1'b0, 16'h0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (instrmem_rd !== 1'b0 || PC !== 16'h3002 || instr !== 16'hA001) begin
      miscompares++;
      $display("FAIL full_stop: rd=%b PC=%h instr=%h, required rd=0 PC=3002 instr=A001", instrmem_rd, PC, instr);
    end
    tick();
    vectors++;
    if (instrmem_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL full_hold: rd=%b, required 0", instrmem_rd);
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (instrmem_rd !== 1'b1 || PC !== 16'h3002 || instr !== 16'hB002 || instr_pc !== 16'h3001) begin
      miscompares++;
      $display("FAIL pop_restart: rd=%b PC=%h instr=%h ipc=%h, required rd=1 PC=3002 instr=B002 ipc=3001",
               instrmem_rd, PC, instr, instr_pc);
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    drive(1'b0, 16'h0, 1'b1, 16'h3004, 1'b0);
    tick();
    drive(1'b1, 16'hD004, 1'b0, 16'h0, 1'b0);
    tick();
    vectors++;
    if (instr_valid !== 1'b1 || PC !== 16'h3005 || instr_pc !== 16'h3004) begin
      miscompares++;
      $display("FAIL pre_branch: valid=%b PC=%h ipc=%h, required 1 3005 3004", instr_valid, PC, instr_pc);
    end
    drive(1'b0, 16'h0, 1'b1, 16'h4000, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (instr_valid !== 1'b0 || PC !== 16'h3005 || instrmem_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_enter: valid=%b PC=%h rd=%b, required 0 3005 1", instr_valid, PC, instrmem_rd);
    end
    tick();
    drive(1'b1, 16'hDEAD, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (PC !== 16'h3005 || instrmem_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_hold: PC=%h rd=%b, required 3005 1", PC, instrmem_rd);
    end
    tick();
    drive(1'b1, 16'hE000, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (PC !== 16'h4000 || instrmem_rd !== 1'b1 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_discard: PC=%h rd=%b valid=%b, required 4000 1 0", PC, instrmem_rd, instr_valid);
    end
    tick();
    vectors++;
    if (instr_valid !== 1'b1 || instr !== 16'hE000 || instr_pc !== 16'h4000 || PC !== 16'h4001) begin
      miscompares++;
      $display("FAIL target_fetch: valid=%b instr=%h ipc=%h PC=%h, required 1 E000 4000 4001", instr_valid, instr, instr_pc, PC);
    end
  endtask

  // Continues from test_redirect_drain (REQ at 4001, one entry buffered).
  task automatic test_redirect_with_complete();
    drive(1'b1, 16'hF00F, 1'b1, 16'h5000, 1'b1);
    tick();
    drive(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (PC !== 16'h5000 || instrmem_rd !== 1'b1 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL br_with_complete: PC=%h rd=%b valid=%b, required 5000 1 0", PC, instrmem_rd, instr_valid);
    end
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 16'h5000 || PC !== 16'h5001) begin
      miscompares++;
      $display("FAIL after_br_complete: valid=%b instr=%h ipc=%h PC=%h, required 1 1234 5000 5001", instr_valid, instr, instr_pc, PC);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    drive(1'b0, 16'h0, 1'b1, 16'hFFFF, 1'b0);
    tick();
    drive(1'b1, 16'h7777, 1'b0, 16'h0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (instr_valid !== 1'b1 || instr !== 16'h7777 || instr_pc !== 16'hFFFF || npc !== 16'h0000 || PC !== 16'h0000) begin
      miscompares++;
      $display("FAIL pc_wrap: valid=%b instr=%h ipc=%h npc=%h PC=%h, required 1 7777 FFFF 0000 0000", instr_valid, instr, instr_pc, npc, PC);
    end
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (instrmem_rd !== 1'b0 || PC !== RST_PC) begin
      miscompares++;
      $display("FAIL midfetch_reset: rd=%b PC=%h, required 0 3000", instrmem_rd, PC);
    end
    drive(1'b1, 16'hBAD0, 1'b0, 16'h0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (instrmem_rd !== 1'b1 || PC !== RST_PC || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL late_complete: rd=%b PC=%h valid=%b, required 1 3000 0", instrmem_rd, PC, instr_valid);
    end
  endtask

  task automatic test_timeout();
    logic exp_err;
`ifdef FETCH_TIMEOUT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    repeat (63) tick();
    vectors++;
    if (fetch_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: err=%b, required 0", fetch_err);
    end
    repeat (3) tick();
    vectors++;
    if (fetch_err !== exp_err || instrmem_rd !== 1'b1 || PC !== RST_PC) begin
      miscompares++;
      $display("FAIL timeout_set: err=%b rd=%b PC=%h, required err=%b rd=1 PC=3000", fetch_err, instrmem_rd, PC, exp_err);
    end
    drive(1'b1, 16'h4444, 1'b0, 16'h0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    tick();
    vectors++;
    if (fetch_err !== exp_err || instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky: err=%b valid=%b, required err=%b valid=1", fetch_err, instr_valid, exp_err);
    end
    do_reset();
    vectors++;
    if (fetch_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: err=%b, required 0", fetch_err);
    end
  endtask

  // Random traffic against a queue-based model of the fetch rules.
  task automatic test_random();
    logic [15:0] mq_pc[$];
    logic [15:0] mq_in[$];
    logic [15:0] m_pc, m_tgt, e_instr, e_ipc, e_npc, dout, tgt;
    logic        m_rd, m_drain, m_err, e_valid, ci, bt, dr, pop, was_rd;
    int          stall;
    do_reset();
    m_pc = RST_PC; m_tgt = '0; m_rd = 1'b0; m_drain = 1'b0; m_err = 1'b0; stall = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      e_valid = (mq_pc.size() != 0);
      e_instr = e_valid ? mq_in[0] : 16'h0;
      e_ipc   = e_valid ? mq_pc[0] : 16'h0;
      e_npc   = e_valid ? mq_pc[0] + 16'd1 : 16'h0;
      vectors++;
      if (PC !== m_pc || instrmem_rd !== m_rd || instr_valid !== e_valid || instr !== e_instr ||
          instr_pc !== e_ipc || npc !== e_npc || fetch_err !== m_err) begin
        miscompares++;
        $display("FAIL rand_cycle%0d: PC=%h rd=%b valid=%b instr=%h ipc=%h npc=%h err=%b, required PC=%h rd=%b valid=%b instr=%h ipc=%h npc=%h err=%b",
                 cyc, PC, instrmem_rd, instr_valid, instr, instr_pc, npc, fetch_err,
                 m_pc, m_rd, e_valid, e_instr, e_ipc, e_npc, m_err);
      end
      bt   = ($urandom_range(0, 11) == 0);
      tgt  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      ci   = m_rd ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
      dr   = ((cyc / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      dout = 16'($urandom);
      drive(ci, dout, bt, tgt, dr);

      was_rd = m_rd;
      pop = (mq_pc.size() != 0) && dr;
      if (bt) begin
        mq_pc.delete();
        mq_in.delete();
      end
      if (!m_rd) begin
        if (bt) begin
          m_pc = tgt;
          m_rd = 1'b1;
        end else begin
          if (pop) begin void'(mq_pc.pop_front()); void'(mq_in.pop_front()); end
          if (mq_pc.size() < DEPTH) m_rd = 1'b1;
        end
      end else if (!m_drain) begin
        if (bt) begin
          if (ci) m_pc = tgt;
          else begin m_drain = 1'b1; m_tgt = tgt; end
        end else begin
          if (pop) begin void'(mq_pc.pop_front()); void'(mq_in.pop_front()); end
          if (ci) begin
            mq_pc.push_back(m_pc);
            mq_in.push_back(dout);
            m_pc = m_pc + 16'd1;
            m_rd = (mq_pc.size() < DEPTH);
          end
        end
      end else begin
        if (!bt && pop) begin void'(mq_pc.pop_front()); void'(mq_in.pop_front()); end
        if (ci) begin
          m_pc    = bt ? tgt : m_tgt;
          m_drain = 1'b0;
        end else if (bt) begin
          m_tgt = tgt;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      if (was_rd && !ci) begin
        stall++;
        if (stall >= 64) m_err = 1'b1;
      end else begin
        stall = 0;
      end
`else
      stall = was_rd ? 0 : stall;
`endif
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fifo_full();
    test_redirect_drain();
    test_redirect_with_complete();
    test_pc_wrap();
    test_reset_midfetch();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
